// File: rtl/split2_if.sv
// split2_if: one input stream and two output branches of the split2 fork.
interface split2_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_in_valid;
  logic                  data_in_ready;
  logic [DATA_WIDTH-1:0] data_out_0;
  logic                  data_out_0_valid;
  logic                  data_out_0_ready;
  logic [DATA_WIDTH-1:0] data_out_1;
  logic                  data_out_1_valid;
  logic                  data_out_1_ready;
  modport slave (
    input  data_in, data_in_valid, data_out_0_ready, data_out_1_ready,
    output data_in_ready, data_out_0, data_out_0_valid, data_out_1, data_out_1_valid
  );
  modport master (
    output data_in, data_in_valid, data_out_0_ready, data_out_1_ready,
    input  data_in_ready, data_out_0, data_out_0_valid, data_out_1, data_out_1_valid
  );
endinterface

// File: rtl/split2_buffered.sv
// split2_buffered: duplicates each accepted beat into two FIFOs that drain independently.
module split2_buffered #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input logic     clk,
  input logic     rst_n,
  split2_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];
  logic [PW-1:0]         wp_q, wp_d;
  logic [PW-1:0]         rp_q [2];
  logic [PW-1:0]         rp_d [2];
  logic [CW-1:0]         cnt_q [2];
  logic [CW-1:0]         cnt_d [2];
  logic                  en_q;
  logic                  push;
  logic [1:0]            pop;
  // Both FIFOs fill in lockstep, so one write pointer serves both; ready only sees registered counts.
  assign bus.data_in_ready    = en_q && cnt_q[0] < FULL && cnt_q[1] < FULL;
  assign push                 = bus.data_in_valid && bus.data_in_ready;
  assign pop                  = {bus.data_out_1_valid & bus.data_out_1_ready,
                                 bus.data_out_0_valid & bus.data_out_0_ready};
  assign bus.data_out_0_valid = cnt_q[0] != '0;
  assign bus.data_out_1_valid = cnt_q[1] != '0;
  assign bus.data_out_0       = mem_q[0][rp_q[0]];
  assign bus.data_out_1       = mem_q[1][rp_q[1]];
  always_comb begin
    wp_d = push ? (wp_q == LAST ? '0 : wp_q + 1'b1) : wp_q;
    for (int b = 0; b < 2; b++) begin
      rp_d[b]  = pop[b] ? (rp_q[b] == LAST ? '0 : rp_q[b] + 1'b1) : rp_q[b];
      cnt_d[b] = cnt_q[b] + CW'(push) - CW'(pop[b]);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= 1'b0;
      wp_q <= '0;
      for (int b = 0; b < 2; b++) begin
        rp_q[b]  <= '0;
        cnt_q[b] <= '0;
        for (int e = 0; e < DEPTH; e++) mem_q[b][e] <= '0;
      end
    end else begin
      en_q <= 1'b1;
      wp_q <= wp_d;
      for (int b = 0; b < 2; b++) begin
        rp_q[b]  <= rp_d[b];
        cnt_q[b] <= cnt_d[b];
        if (push) mem_q[b][wp_q] <= bus.data_in;
      end
    end
  end
`ifndef SYNTHESIS
  for (genvar b = 0; b < 2; b++) begin : chk
    assert property (@(posedge clk) disable iff (!rst_n) !(push && cnt_q[b] == FULL));
    assert property (@(posedge clk) disable iff (!rst_n) !(pop[b] && cnt_q[b] == '0));
  end
  assert property (@(posedge clk) disable iff (!rst_n)
    (cnt_q[0] > cnt_q[1] ? cnt_q[0] - cnt_q[1] : cnt_q[1] - cnt_q[0]) <= FULL);
`endif
endmodule

// File: tb/tb_split2_buffered.sv
// tb_split2_buffered: directed vectors on a DEPTH=2 fork, then random traffic on DEPTH=2 and DEPTH=5.
module tb_split2_buffered;
  localparam int N = 10000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0][31:0] din, d0, d1;
  logic [1:0] vin, r0, r1, rdy, v0, v1;
  logic [1:0] acc;
  int nacc [2];
  logic [31:0] sb [4][$];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : inst
    split2_if #(.DATA_WIDTH(32)) bus ();
    split2_buffered #(.DATA_WIDTH(32), .DEPTH(g == 0 ? 2 : 5)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
    );
    assign bus.data_in          = din[g];
    assign bus.data_in_valid    = vin[g];
    assign bus.data_out_0_ready = r0[g];
    assign bus.data_out_1_ready = r1[g];
    assign rdy[g]               = bus.data_in_ready;
    assign v0[g]                = bus.data_out_0_valid;
    assign v1[g]                = bus.data_out_1_valid;
    assign d0[g]                = bus.data_out_0;
    assign d1[g]                = bus.data_out_1;
  end
  typedef struct {
    bit          vi;
    logic [31:0] di;
    bit          a, b;
    bit          er, e0, e1;
  } vec_t;
  vec_t tv [21];
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", n, act, exp);
    end
  endtask
  // Called at a negedge with inputs already driven; handshakes resolve at the coming posedge.
  task automatic tick();
    #1;
    for (int g = 0; g < 2; g++) begin
      for (int br = 0; br < 2; br++) begin
        logic v, r;
        logic [31:0] d;
        int k;
        v = br ? v1[g] : v0[g];
        r = br ? r1[g] : r0[g];
        d = br ? d1[g] : d0[g];
        k = g * 2 + br;
        if (v && r) begin
          if (sb[k].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_empty inst%0d br%0d got=%h expected=none", g, br, d);
          end else chk($sformatf("data inst%0d br%0d", g, br), d, sb[k].pop_front());
        end
      end
      acc[g] = vin[g] && rdy[g];
      if (acc[g]) begin
        sb[g*2].push_back(din[g]);
        sb[g*2+1].push_back(din[g]);
        nacc[g]++;
      end
    end
    @(negedge clk);
  endtask
  initial begin
    int cyc;
    tv[0]  = '{1, 32'hA,  1, 0, 1, 0, 0};
    tv[1]  = '{1, 32'hB,  1, 0, 1, 1, 1};
    tv[2]  = '{1, 32'hC,  1, 0, 0, 1, 1};
    tv[3]  = '{1, 32'hC,  1, 0, 0, 0, 1};
    tv[4]  = '{1, 32'hC,  1, 1, 0, 0, 1};
    tv[5]  = '{1, 32'hC,  1, 1, 1, 0, 1};
    tv[6]  = '{0, 32'h0,  1, 1, 1, 1, 1};
    tv[7]  = '{0, 32'h0,  1, 1, 1, 0, 0};
    tv[8]  = '{1, 32'hD,  0, 0, 1, 0, 0};
    tv[9]  = '{1, 32'hE,  0, 0, 1, 1, 1};
    tv[10] = '{1, 32'hF,  1, 0, 0, 1, 1};
    tv[11] = '{1, 32'hF,  1, 0, 0, 1, 1};
    tv[12] = '{1, 32'hF,  1, 0, 0, 0, 1};
    tv[13] = '{1, 32'hF,  0, 1, 0, 0, 1};
    tv[14] = '{1, 32'hF,  0, 0, 1, 0, 1};
    tv[15] = '{0, 32'h0,  1, 1, 0, 1, 1};
    tv[16] = '{0, 32'h0,  0, 1, 1, 0, 1};
    tv[17] = '{1, 32'h44, 0, 0, 1, 0, 0};
    tv[18] = '{1, 32'h55, 1, 1, 1, 1, 1};
    tv[19] = '{0, 32'h0,  1, 1, 1, 1, 1};
    tv[20] = '{0, 32'h0,  1, 1, 1, 0, 0};
    din = '0; vin = '0; r0 = '0; r1 = '0; acc = '0;
    nacc[0] = 0; nacc[1] = 0;
    repeat (2) @(negedge clk);
    chk("reset rdy", rdy[0], 0);
    chk("reset v0", v0[0], 0);
    chk("reset v1", v1[0], 0);
    chk("reset d0", d0[0], 0);
    chk("reset d1", d1[0], 0);
    rst_n = 1'b1;
    #1 chk("rdy before first edge", rdy[0], 0);
    @(negedge clk);
    chk("rdy after first edge", rdy[0], 1);
    for (int i = 0; i < 18; i++) begin
      vin[0] = i < 16; din[0] = 32'(i + 1); r0[0] = 1'b1; r1[0] = 1'b1;
      chk($sformatf("stream rdy %0d", i), rdy[0], 1);
      chk($sformatf("stream v0 %0d", i), v0[0], (i >= 1 && i <= 16));
      chk($sformatf("stream v1 %0d", i), v1[0], (i >= 1 && i <= 16));
      tick();
    end
    for (int i = 0; i < 21; i++) begin
      vin[0] = tv[i].vi; din[0] = tv[i].di; r0[0] = tv[i].a; r1[0] = tv[i].b;
      chk($sformatf("vec%0d rdy", i), rdy[0], tv[i].er);
      chk($sformatf("vec%0d v0", i), v0[0], tv[i].e0);
      chk($sformatf("vec%0d v1", i), v1[0], tv[i].e1);
      tick();
    end
    vin[0] = 1'b1; din[0] = 32'h77; r0[0] = 1'b0; r1[0] = 1'b0;
    tick();
    din[0] = 32'h78;
    tick();
    vin[0] = 1'b0;
    chk("prereset v0", v0[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async v0", v0[0], 0);
    chk("async v1", v1[0], 0);
    chk("async rdy", rdy[0], 0);
    for (int k = 0; k < 4; k++) sb[k].delete();
    acc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    r0[0] = 1'b1; r1[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("post reset v0 %0d", i), v0[0], 0);
      chk($sformatf("post reset v1 %0d", i), v1[0], 0);
      tick();
    end
    nacc[0] = 0; nacc[1] = 0; vin = '0; acc = '0;
    cyc = 0;
    while ((nacc[0] < N || nacc[1] < N ||
            sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() != 0) && cyc < 60000) begin
      for (int g = 0; g < 2; g++) begin
        if (!vin[g] || acc[g]) begin
          vin[g] = nacc[g] < N && $urandom_range(9) < 7;
          din[g] = $urandom;
        end
        r0[g] = nacc[g] >= N || $urandom_range(9) < 6;
        r1[g] = nacc[g] >= N || $urandom_range(9) < 6;
      end
      tick();
      cyc++;
    end
    chk("random cycle budget", cyc < 60000, 1);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("random accepted inst%0d", g), nacc[g], N);
      chk($sformatf("random leftover br0 inst%0d", g), sb[g*2].size(), 0);
      chk($sformatf("random leftover br1 inst%0d", g), sb[g*2+1].size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
